// File: rtl/chk_pkg.sv
// Shared definitions for the test-port checker: FSM encoding, marker defaults
// and the special error-count values.
package chk_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      CHECK  = 2'b01,
      REPORT = 2'b10
   } state_t;

   localparam logic [31:0] DEF_BEGIN_SYM = 32'h00000168;
   localparam logic [31:0] DEF_END_SYM   = 32'hFFFFFD5D;

   // 255 marks "no run started", so real mismatch counts stop one short of it
   localparam logic [7:0]  ERR_NO_RUN    = 8'd255;
   localparam logic [7:0]  ERR_MAX       = 8'd254;

endpackage

// File: rtl/chk_answer_ram.sv
// Answer memory: synchronous write, asynchronous read so the compare sees the
// expected word in the same cycle as the bus hit.
module chk_answer_ram #(
   parameter int DW    = 32,
   parameter int DEPTH = 32,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [DW-1:0] i_wdata,
   input  logic [AW-1:0] i_raddr,
   output logic [DW-1:0] o_rdata
);

   logic [DW-1:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/test_port_checker.sv
// Watches a memory-mapped test port, compares each written word against a
// preloaded answer table and reports mismatch count, duration and timeout.
module test_port_checker
   import chk_pkg::*;
#(
   parameter int              DW          = 32,
   parameter logic [29:0]     TEST_PORT   = 30'h10,
   parameter logic [DW-1:0]   BEGIN_SYM   = DW'(DEF_BEGIN_SYM),
   parameter int              CHECK_NUM   = 19,
   parameter int              DEPTH       = 32,
   parameter int              AW          = $clog2(DEPTH),
   parameter bit              SWAP_EN     = 1'b1,
   parameter logic [15:0]     TIMEOUT_CYC = 16'hFFFF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [29:0]   addr,
   input  logic [DW-1:0] data,
   input  logic          wen,
   input  logic          ans_we,
   input  logic [AW-1:0] ans_waddr,
   input  logic [DW-1:0] ans_wdata,
   input  logic          clear,
   output logic [7:0]    error_num,
   output logic [15:0]   duration,
   output logic          finish,
   output logic          timeout,
   output logic [AW-1:0] first_err_idx
);

   // idx must be able to hold CHECK_NUM itself, which may equal DEPTH
   localparam int            IW       = AW + 1;
   localparam logic [IW-1:0] IDX_END  = IW'(CHECK_NUM);
   localparam logic [15:0]   DUR_LAST = TIMEOUT_CYC - 16'd1;

   state_t        r_state;
   state_t        w_nextState;
   logic          r_prevWen;
   logic [IW-1:0] r_idx;
   logic [15:0]   r_duration;
   logic [7:0]    r_errNum;
   logic          r_timeout;
   logic [AW-1:0] r_firstErr;

   logic [DW-1:0] w_data;
   logic [DW-1:0] w_ansData;
   logic          w_hit;
   logic          w_startRun;
   logic          w_idxDone;
   logic          w_timeUp;
   logic          w_checkHit;
   logic          w_mismatch;

   generate
      if (SWAP_EN) begin : g_swap
         for (genvar b = 0; b < DW/8; b++) begin : g_byte
            assign w_data[8*b +: 8] = data[DW-8-8*b +: 8];
         end
      end else begin : g_pass
         assign w_data = data;
      end
   endgenerate

   // A held wen during a cache stall must count once, hence the edge detect
   assign w_hit      = wen && !r_prevWen && (addr == TEST_PORT);
   assign w_startRun = (r_state == IDLE) && w_hit && (w_data == BEGIN_SYM);
   assign w_idxDone  = (r_idx >= IDX_END);
   assign w_timeUp   = !w_idxDone && (r_duration == DUR_LAST);
   assign w_checkHit = (r_state == CHECK) && w_hit && !w_idxDone;
   assign w_mismatch = (w_data != w_ansData);

   chk_answer_ram #(
      .DW    (DW),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_ansRam (
      .clk     (clk),
      .i_we    (ans_we && (r_state != CHECK)),
      .i_waddr (ans_waddr),
      .i_wdata (ans_wdata),
      .i_raddr (r_idx[AW-1:0]),
      .o_rdata (w_ansData)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE:    if (w_startRun) w_nextState = CHECK;
         CHECK:   if (w_idxDone || w_timeUp) w_nextState = REPORT;
         REPORT:  if (clear) w_nextState = IDLE;
         default: w_nextState = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_prevWen  <= 1'b0;
         r_idx      <= '0;
         r_duration <= '0;
         r_errNum   <= ERR_NO_RUN;
         r_timeout  <= 1'b0;
         r_firstErr <= '0;
      end else begin
         r_prevWen <= wen;
         case (r_state)
            IDLE: begin
               if (w_startRun) begin
                  r_idx      <= '0;
                  r_duration <= '0;
                  r_timeout  <= 1'b0;
                  r_errNum   <= 8'd0;
               end
            end
            CHECK: begin
               // Duration freezes on the cycle that decides the exit
               if (w_timeUp) begin
                  r_timeout <= 1'b1;
               end else if (!w_idxDone && (r_duration != 16'hFFFF)) begin
                  r_duration <= r_duration + 16'd1;
               end
               if (w_checkHit) begin
                  r_idx <= r_idx + IW'(1);
                  if (w_mismatch) begin
                     if (r_errNum == 8'd0) begin
                        r_firstErr <= r_idx[AW-1:0];
                     end
                     if (r_errNum < ERR_MAX) begin
                        r_errNum <= r_errNum + 8'd1;
                     end
                  end
               end
            end
            REPORT: begin
               if (clear) begin
                  r_errNum <= ERR_NO_RUN;
               end
            end
            default: ;
         endcase
      end
   end

   assign error_num     = r_errNum;
   assign duration      = r_duration;
   assign finish        = (r_state == REPORT);
   assign timeout       = r_timeout;
   assign first_err_idx = r_firstErr;

endmodule

// File: tb/tb_test_port_checker.sv
// Self-checking bench for test_port_checker: directed vector table, hand-written
// corner sequences and randomized runs scored against a behavioural model.
module tb_test_port_checker;

   localparam int          NW        = 19;
   localparam int          AW        = 5;
   localparam logic [15:0] TO        = 16'd160;
   localparam logic [29:0] TP        = 30'h10;
   localparam logic [31:0] BEGIN_BUS = 32'h68010000;

   logic          clk = 1'b0;
   logic          rst;
   logic [29:0]   addr;
   logic [31:0]   data;
   logic          wen;
   logic          ans_we;
   logic [AW-1:0] ans_waddr;
   logic [31:0]   ans_wdata;
   logic          clear;
   logic [7:0]    error_num;
   logic [15:0]   duration;
   logic          finish;
   logic          timeout;
   logic [AW-1:0] first_err_idx;

   always #5 clk = ~clk;

   test_port_checker #(
      .DW          (32),
      .TEST_PORT   (TP),
      .BEGIN_SYM   (32'h00000168),
      .CHECK_NUM   (NW),
      .DEPTH       (32),
      .SWAP_EN     (1'b1),
      .TIMEOUT_CYC (TO)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .addr          (addr),
      .data          (data),
      .wen           (wen),
      .ans_we        (ans_we),
      .ans_waddr     (ans_waddr),
      .ans_wdata     (ans_wdata),
      .clear         (clear),
      .error_num     (error_num),
      .duration      (duration),
      .finish        (finish),
      .timeout       (timeout),
      .first_err_idx (first_err_idx)
   );

   typedef struct {
      int         hold;
      int         gap;
      int         nWords;
      int         badA;
      int         badB;
      logic [7:0] expErr;
      int         expFirst;
      logic       expTimeout;
      string      name;
   } vec_t;

   vec_t        vecs[4];
   int          nChecks = 0;
   int          nFails = 0;
   int          cycleCnt = 0;
   logic [31:0] ansModel[NW];
   logic [31:0] busWords[NW];
   int          hitCycle[NW];
   int          beginCycle;

   function automatic logic [31:0] swapBytes(input logic [31:0] w);
      return {w[7:0], w[15:8], w[23:16], w[31:24]};
   endfunction

   // Model: mismatches are simply bus words that, read back in byte order, differ from the table
   function automatic int modelErrors(input int n);
      int cnt = 0;
      for (int i = 0; i < n; i++) if (swapBytes(busWords[i]) != ansModel[i]) cnt++;
      return (cnt > 254) ? 254 : cnt;
   endfunction

   function automatic int modelFirstErr(input int n);
      for (int i = 0; i < n; i++) if (swapBytes(busWords[i]) != ansModel[i]) return i;
      return -1;
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
      cycleCnt++;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic busWrite(input logic [29:0] a, input logic [31:0] d, input int hold,
                           input int gap, output int hitAt);
      addr = a;
      data = d;
      wen  = 1'b1;
      cyc();
      hitAt = cycleCnt;
      repeat (hold - 1) cyc();
      wen = 1'b0;
      repeat (gap + 1) cyc();
   endtask

   task automatic loadAnswers();
      for (int i = 0; i < NW; i++) begin
         ans_we    = 1'b1;
         ans_waddr = AW'(i);
         ans_wdata = ansModel[i];
         cyc();
      end
      ans_we = 1'b0;
   endtask

   task automatic applyStimulus(input int nWords, input int hold, input int gap,
                                input bit randTiming, input bit distract);
      int h, g, dummy;
      h = randTiming ? int'($urandom_range(1, hold)) : hold;
      g = randTiming ? int'($urandom_range(0, gap)) : gap;
      busWrite(TP, BEGIN_BUS, h, g, beginCycle);
      for (int i = 0; i < nWords; i++) begin
         if (distract && ($urandom_range(0, 3) == 0)) busWrite(TP + 30'd1, $urandom, 1, 0, dummy);
         h = randTiming ? int'($urandom_range(1, hold)) : hold;
         g = randTiming ? int'($urandom_range(0, gap)) : gap;
         busWrite(TP, busWords[i], h, g, hitCycle[i]);
      end
   endtask

   task automatic checkReport(input string name, input int expErr, input int expFirst,
                              input logic expTo, input int expDur);
      int waited = 0;
      while (finish !== 1'b1 && waited < 400) begin
         cyc();
         waited++;
      end
      checkOutput({name, ".finish"}, 32'(finish), 32'd1);
      checkOutput({name, ".error_num"}, 32'(error_num), 32'(expErr));
      checkOutput({name, ".timeout"}, 32'(timeout), 32'(expTo));
      checkOutput({name, ".duration"}, 32'(duration), 32'(expDur));
      if (expErr >= 1 && expErr <= 254)
         checkOutput({name, ".first_err_idx"}, 32'(first_err_idx), 32'(expFirst));
   endtask

   task automatic clearRun(input string name);
      clear = 1'b1;
      cyc();
      clear = 1'b0;
      checkOutput({name, ".clear_err"}, 32'(error_num), 32'd255);
      checkOutput({name, ".clear_finish"}, 32'(finish), 32'd0);
   endtask

   task automatic defaultAnswers();
      ansModel[0] = 32'h0000DEAD;
      for (int i = 1; i < NW - 1; i++) ansModel[i] = 32'hA5A50000 + 32'(i) * 32'h0101;
      ansModel[NW-1] = chk_pkg::DEF_END_SYM;
   endtask

   task automatic correctWords();
      for (int i = 0; i < NW; i++) busWords[i] = swapBytes(ansModel[i]);
   endtask

   initial begin
      int dummy;
      int expDur;
      vecs[0] = '{1, 0, NW, -1, -1, 8'd0, 0, 1'b0, "basic"};
      vecs[1] = '{1, 0, NW,  3,  7, 8'd2, 3, 1'b0, "twoBad"};
      vecs[2] = '{4, 1, NW, -1, -1, 8'd0, 0, 1'b0, "held4"};
      vecs[3] = '{1, 0, 5,  -1, -1, 8'd0, 0, 1'b1, "timeout"};

      rst = 1'b0; addr = '0; data = '0; wen = 1'b0;
      ans_we = 1'b0; ans_waddr = '0; ans_wdata = '0; clear = 1'b0;
      repeat (3) cyc();
      checkOutput("reset.error_num", 32'(error_num), 32'd255);
      checkOutput("reset.duration", 32'(duration), 32'd0);
      checkOutput("reset.finish", 32'(finish), 32'd0);
      checkOutput("reset.timeout", 32'(timeout), 32'd0);
      checkOutput("reset.first_err_idx", 32'(first_err_idx), 32'd0);
      rst = 1'b1;
      cyc();

      defaultAnswers();
      loadAnswers();

      for (int v = 0; v < 4; v++) begin
         for (int i = 0; i < NW; i++)
            busWords[i] = swapBytes((i == vecs[v].badA || i == vecs[v].badB) ?
                                    (ansModel[i] ^ 32'h00000100) : ansModel[i]);
         applyStimulus(vecs[v].nWords, vecs[v].hold, vecs[v].gap, 1'b0, 1'b0);
         expDur = vecs[v].expTimeout ? int'(TO) - 1 : hitCycle[vecs[v].nWords-1] - beginCycle;
         checkReport(vecs[v].name, int'(vecs[v].expErr), vecs[v].expFirst, vecs[v].expTimeout, expDur);
         clearRun(vecs[v].name);
      end

      // Clear is ignored mid-run; hits are ignored once reporting
      correctWords();
      busWrite(TP, BEGIN_BUS, 1, 0, beginCycle);
      for (int i = 0; i < NW; i++) begin
         if (i == 5) begin
            clear = 1'b1;
            cyc();
            clear = 1'b0;
         end
         busWrite(TP, busWords[i], 1, 0, hitCycle[i]);
      end
      expDur = hitCycle[NW-1] - beginCycle;
      checkReport("clearInCheck", 0, 0, 1'b0, expDur);
      busWrite(TP, 32'hDEADBEEF, 1, 0, dummy);
      checkOutput("reportHold.error_num", 32'(error_num), 32'd0);
      checkOutput("reportHold.duration", 32'(duration), 32'(expDur));
      checkOutput("reportHold.finish", 32'(finish), 32'd1);
      clearRun("reportHold");

      // Wrong address, non-begin data, and answer loads during CHECK all ignored
      busWrite(30'h11, BEGIN_BUS, 1, 0, dummy);
      checkOutput("wrongAddr.error_num", 32'(error_num), 32'd255);
      busWrite(TP, busWords[0], 1, 0, dummy);
      checkOutput("nonBegin.error_num", 32'(error_num), 32'd255);
      checkOutput("nonBegin.finish", 32'(finish), 32'd0);
      busWrite(TP, BEGIN_BUS, 1, 0, beginCycle);
      checkOutput("begin.error_num", 32'(error_num), 32'd0);
      for (int i = 0; i < NW; i++) begin
         if (i == 4) begin
            ans_we = 1'b1;
            ans_waddr = AW'(10);
            ans_wdata = ~ansModel[10];
            cyc();
            ans_we = 1'b0;
         end
         if (i == 6) busWrite(30'h11, busWords[6], 1, 0, dummy);
         busWrite(TP, busWords[i], 1, 0, hitCycle[i]);
      end
      checkReport("dropLoads", 0, 0, 1'b0, hitCycle[NW-1] - beginCycle);
      clearRun("dropLoads");

      // Reset mid-run aborts; clear in IDLE does nothing; a rerun passes
      busWrite(TP, BEGIN_BUS, 1, 0, beginCycle);
      for (int i = 0; i < 10; i++) busWrite(TP, busWords[i], 1, 0, hitCycle[i]);
      rst = 1'b0;
      #2;
      checkOutput("midReset.error_num", 32'(error_num), 32'd255);
      checkOutput("midReset.finish", 32'(finish), 32'd0);
      checkOutput("midReset.duration", 32'(duration), 32'd0);
      cyc();
      rst = 1'b1;
      cyc();
      clear = 1'b1;
      cyc();
      clear = 1'b0;
      checkOutput("idleClear.error_num", 32'(error_num), 32'd255);
      applyStimulus(NW, 1, 0, 1'b0, 1'b0);
      checkReport("rerun", 0, 0, 1'b0, hitCycle[NW-1] - beginCycle);
      clearRun("rerun");

      // Last word lands exactly as the timeout would fire: completion wins
      busWrite(TP, BEGIN_BUS, 1, 0, beginCycle);
      for (int i = 0; i < NW - 1; i++) busWrite(TP, busWords[i], 1, 0, hitCycle[i]);
      while (cycleCnt < beginCycle + int'(TO) - 2) cyc();
      busWrite(TP, busWords[NW-1], 1, 0, hitCycle[NW-1]);
      checkOutput("tie.hit_offset", 32'(hitCycle[NW-1] - beginCycle), 32'(int'(TO) - 1));
      checkReport("tie", 0, 0, 1'b0, int'(TO) - 1);
      clearRun("tie");

      for (int r = 0; r < 8; r++) begin
         for (int i = 0; i < NW; i++) ansModel[i] = $urandom;
         loadAnswers();
         for (int i = 0; i < NW; i++)
            busWords[i] = swapBytes(($urandom_range(0, 5) == 0) ?
                                    (ansModel[i] ^ ($urandom | 32'd1)) : ansModel[i]);
         applyStimulus(NW, 2, 1, 1'b1, 1'b1);
         checkReport($sformatf("rand%0d", r), modelErrors(NW), modelFirstErr(NW), 1'b0,
                     hitCycle[NW-1] - beginCycle);
         clearRun($sformatf("rand%0d", r));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule

// File: doc/test_port_checker.md
TEST_PORT_CHECKER -- requirements
Module: test_port_checker

Interface
REQ-001 Parameter DW, default 32: monitored bus data width, a multiple of 8.
REQ-002 Parameter TEST_PORT, default 30'h10: word address of the test port.
REQ-003 Parameter BEGIN_SYM, default 32'h00000168: start marker value, compared after byte reorder.
REQ-004 Parameter CHECK_NUM, default 19: number of checked words; range 1..DEPTH.
REQ-005 Parameter DEPTH, default 32, and AW = clog2(DEPTH): answer-memory size.
REQ-006 Parameter SWAP_EN, default 1: 1 = byte-reverse data (little-endian to readable); 0 = pass data through unchanged.
REQ-007 Parameter TIMEOUT_CYC, default 16'hFFFF: CHECK-state cycle limit.
REQ-008 clk  in  1  single clock; all state updates on posedge.
REQ-009 rst  in  1  asynchronous, active-low reset.
REQ-010 addr  in  30  monitored bus word address.
REQ-011 data  in  DW  monitored bus write data.
REQ-012 wen  in  1  monitored bus write enable; may stay high for several cycles during a cache stall.
REQ-013 ans_we / ans_waddr[AW-1:0] / ans_wdata[DW-1:0]  in  answer-memory load port.
REQ-014 clear  in  1  returns the block from REPORT to IDLE.
REQ-015 error_num  out  8  mismatch count; 255 = no run started.
REQ-016 duration  out  16  cycles spent in CHECK.
REQ-017 finish  out  1  high while in REPORT.
REQ-018 timeout  out  1  run ended by timeout rather than completion.
REQ-019 first_err_idx  out  AW  index of the first mismatching word; valid when error_num is 1..254.

Function
REQ-020 A hit SHALL be a cycle with wen=1, prev_wen=0 and addr==TEST_PORT; prev_wen is wen registered one cycle earlier, so a held wen yields exactly one hit.
REQ-021 In IDLE, a hit with reordered data == BEGIN_SYM SHALL clear idx, duration and timeout, set error_num=0 and enter CHECK on the next cycle.
REQ-022 In IDLE, any other hit SHALL be ignored; error_num stays 255.
REQ-023 In CHECK, each hit SHALL compare reordered data with ans_mem[idx] and then increment idx.
REQ-024 On mismatch, error_num SHALL increment and saturate at 254; the first mismatch SHALL capture idx into first_err_idx.
REQ-025 In CHECK, duration SHALL increment every cycle and saturate at 16'hFFFF.
REQ-026 When idx reaches CHECK_NUM, the block SHALL enter REPORT on the following cycle; the hit that completes the count is still compared.
REQ-027 When duration == TIMEOUT_CYC-1 with idx < CHECK_NUM, the block SHALL enter REPORT with timeout=1.
REQ-028 If completion and timeout occur in the same cycle, completion SHALL take priority and timeout SHALL remain 0.
REQ-029 In REPORT, finish=1 and all counters SHALL hold; hits SHALL be ignored.
REQ-030 clear in REPORT SHALL enter IDLE with error_num=255; clear is ignored in other states.
REQ-031 ans_we SHALL write only in IDLE or REPORT; a load in CHECK SHALL be dropped.
REQ-032 Answer reads SHALL be combinational from registered storage: zero added latency; compare result is registered into error_num in the same edge as the idx increment.

Reset
REQ-033 On rst=0: state=IDLE, idx=0, duration=0, error_num=255, finish=0, timeout=0, first_err_idx=0, prev_wen=0; answer memory contents are not reset.
REQ-034 Reset asserted mid-CHECK SHALL abort the run immediately; no report is produced.

Structure
REQ-035 Package chk_pkg SHALL hold the state encoding (IDLE=2'b00, CHECK=2'b01, REPORT=2'b10), the default BEGIN_SYM and the default END_SYM 32'hFFFFFD5D.
REQ-036 Sub-module chk_answer_ram SHALL provide a DEPTH x DW memory with synchronous write and asynchronous read.
REQ-037 Byte reordering SHALL be a generate-selected combinational function of SWAP_EN.

Verification
REQ-038 Load 19 answers (0000DEAD ... FFFFFD5D), drive begin 0x68010000 then all 19 correct words byte-swapped -> finish=1, error_num=0, timeout=0.
REQ-039 Same run with words 3 and 7 corrupted -> error_num=2, first_err_idx=3.
REQ-040 Each test-port write held for 4 cycles of wen -> 19 hits counted, error_num=0.
REQ-041 TIMEOUT_CYC=50 and only 5 words sent -> REPORT at duration 49, timeout=1.
REQ-042 Write to addr 0x11 with correct data, and ans_we pulses during CHECK -> writes ignored, stored answers unchanged, idx unaffected.
REQ-043 rst pulsed after 10 words, then clear and a rerun -> error_num=255 after reset; the full rerun passes.
